// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with mid-bit sampling, parity/framing checks and a one-word output holding register
module uart_rx_cfg #(
  parameter int CLK_DIV   = 427,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int TW = $clog2(CLK_DIV);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s, half_bit, full_bit;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, dout_q, dout_d;
  logic                 armed_q, armed_d, pe_q, pe_d, fe_q, fe_d, done_q, done_d;
  logic                 vld_q, vld_d, pe_o_q, pe_o_d, fe_o_q, fe_o_d, ovr_q, ovr_d;
  assign rx_s       = sync_q[1];
  assign half_bit   = tmr_q == TW'(CLK_DIV/2 - 1);
  assign full_bit   = tmr_q == TW'(CLK_DIV - 1);
  assign busy       = state_q != IDLE;
  assign data_out   = dout_q;
  assign data_valid = vld_q;
  assign frame_err  = fe_o_q;
  assign overrun    = ovr_q;
  assign parity_err = (PARITY != 0) & pe_o_q;
  // Frame FSM: start qualification, mid-bit sampling of data/parity/stop, and the re-arm rule after a low stop bit
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    armed_d = armed_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d   = '0;
        armed_d = armed_q | rx_s;
        if (!rx_s && armed_q) begin
          state_d = START;
          pe_d    = 1'b0;
          fe_d    = 1'b0;
        end
      end
      START: if (half_bit) begin
        tmr_d   = '0;
        cnt_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (full_bit) begin
        tmr_d = '0;
        cnt_d = cnt_q + 1'b1;
        sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
        if (cnt_q == 4'(DATA_BITS - 1)) begin
          cnt_d   = '0;
          state_d = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: if (full_bit) begin
        tmr_d   = '0;
        pe_d    = ^{sh_q, rx_s, PARITY == 1};
        state_d = STOP;
      end
      STOP: if (full_bit) begin
        tmr_d = '0;
        cnt_d = cnt_q + 1'b1;
        fe_d  = fe_q | ~rx_s;
        if (cnt_q == 4'(STOP_BITS - 1)) begin
          state_d = IDLE;
          armed_d = rx_s;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Output holding register: load on completion unless a held word is still unaccepted, in which case drop and flag overrun
  always_comb begin
    dout_d = dout_q;
    pe_o_d = pe_o_q;
    fe_o_d = fe_o_q;
    vld_d  = vld_q & ~data_ready;
    ovr_d  = done_q & vld_q & ~data_ready;
    if (done_q && !(vld_q && !data_ready)) begin
      dout_d = sh_q;
      pe_o_d = pe_q;
      fe_o_d = fe_q;
      vld_d  = 1'b1;
    end
  end
  // Synchronizer and receive-side state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      armed_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      armed_q <= armed_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      done_q  <= done_d;
    end
  end
  // Consumer-facing registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
      pe_o_q <= 1'b0;
      fe_o_q <= 1'b0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      pe_o_q <= pe_o_d;
      fe_o_q <= fe_o_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: frame-level stimulus into three receiver builds (8N1, 8E1, 5N2) checked against an accepted-word scoreboard
module tb_uart_rx_cfg;
  localparam int CD = 16;
  localparam int NB [3] = '{8, 8, 5};
  localparam int PM [3] = '{0, 2, 0};
  localparam int SB [3] = '{1, 1, 2};
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] rx_v, rdy, vld, pe, fe, ovr, bsy;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int rise0 = 0, vcnt0 = 0, rd = 0;
  int ovr_n [3] = '{0, 0, 0};
  logic v0_prev = 1'b0;
  logic [12:0] acc [$];
  logic [12:0] exp_q [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_rx_cfg #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[0]), .data_out(d0), .data_valid(vld[0]), .data_ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ovr[0]), .busy(bsy[0]));
  uart_rx_cfg #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[1]), .data_out(d1), .data_valid(vld[1]), .data_ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ovr[1]), .busy(bsy[1]));
  uart_rx_cfg #(.CLK_DIV(CD), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[2]), .data_out(d2), .data_valid(vld[2]), .data_ready(rdy[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ovr[2]), .busy(bsy[2]));
  // Record every accepted word as {dut, data, parity_err, frame_err}, plus overrun pulses and DUT0 valid timing
  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && rdy[i])
        acc.push_back({2'(i), (i == 0) ? {1'b0, d0} : (i == 1) ? {1'b0, d1} : {4'b0, d2}, pe[i], fe[i]});
      ovr_n[i] += int'(ovr[i]);
    end
    if (vld[0] && !v0_prev) rise0 = cyc;
    v0_prev = vld[0];
    vcnt0 += int'(vld[0]);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic put_bit(input int s, input logic b);
    rx_v[s] = b;
    repeat (CD) @(negedge clk);
  endtask
  task automatic idle(input int s, input int bits);
    rx_v[s] = 1'b1;
    repeat (bits * CD) @(negedge clk);
  endtask
  task automatic send(input int s, input logic [8:0] w, input logic bad_par, input logic [1:0] stops);
    logic p;
    p = 1'b0;
    put_bit(s, 1'b0);
    for (int i = 0; i < NB[s]; i++) begin
      put_bit(s, w[i]);
      p ^= w[i];
    end
    if (PM[s] != 0) put_bit(s, ((PM[s] == 1) ? ~p : p) ^ bad_par);
    for (int i = 0; i < SB[s]; i++) put_bit(s, stops[i]);
  endtask
  task automatic expect_word(input int s, input logic [8:0] w, input logic p_err, input logic f_err);
    exp_q.push_back({2'(s), w & 9'((1 << NB[s]) - 1), p_err, f_err});
  endtask
  task automatic drain();
    int n;
    repeat (2 * CD) @(negedge clk);
    #2;
    n = acc.size() - rd;
    check("word_count", n, exp_q.size());
    for (int j = 0; j < exp_q.size() && j < n; j++) check("word", acc[rd + j], exp_q[j]);
    rd = acc.size();
    exp_q.delete();
  endtask
  initial begin
    int c0, v, o, done_c;
    logic seen;
    logic [7:0] w;
    logic [8:0] rw;
    logic [1:0] st;
    logic bp;
    rst_n = 1'b0;
    rx_v = '1;
    rdy = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", vld, 0);
    check("rst_busy", bsy, 0);
    check("rst_flags", {pe, fe, ovr}, 0);
    check("rst_data", {d0, d1, d2}, 0);
    rst_n = 1'b1;
    repeat (CD) @(negedge clk);
    rdy[0] = 1'b1;
    v = vcnt0;
    c0 = cyc;
    expect_word(0, 9'hA5, 0, 0);
    send(0, 9'hA5, 0, 2'b11);
    check("a5_latency", rise0 - c0, 2 + 1 + CD/2 + 9*CD + 1);
    drain();
    check("a5_valid_cycles", vcnt0 - v, 1);
    rdy[1] = 1'b1;
    expect_word(1, 9'h3C, 0, 0);
    send(1, 9'h3C, 0, 2'b11);
    idle(1, 1);
    expect_word(1, 9'h3C, 1, 0);
    send(1, 9'h3C, 1, 2'b11);
    drain();
    expect_word(0, 9'h5A, 0, 1);
    send(0, 9'h5A, 0, 2'b00);
    repeat (40 * CD) @(negedge clk);
    check("break_busy", bsy[0], 0);
    drain();
    idle(0, 2);
    expect_word(0, 9'h55, 0, 0);
    send(0, 9'h55, 0, 2'b11);
    drain();
    v = vcnt0;
    c0 = cyc;
    rx_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_v[0] = 1'b1;
    seen = 1'b0;
    done_c = 0;
    for (int k = 0; k < 3 * CD && done_c == 0; k++) begin
      @(negedge clk);
      if (bsy[0]) seen = 1'b1;
      else if (seen) done_c = cyc - c0;
    end
    check("glitch_busy_seen", seen, 1);
    check("glitch_busy_end", done_c > 0 && done_c <= CD/2 + 3, 1);
    drain();
    check("glitch_valid", vcnt0 - v, 0);
    rdy[0] = 1'b0;
    o = ovr_n[0];
    send(0, 9'h11, 0, 2'b11);
    send(0, 9'h22, 0, 2'b11);
    repeat (4) @(negedge clk);
    check("ovr_valid", vld[0], 1);
    check("ovr_data", d0, 8'h11);
    check("ovr_pulses", ovr_n[0] - o, 1);
    rdy[0] = 1'b1;
    expect_word(0, 9'h11, 0, 0);
    @(negedge clk);
    check("ovr_valid_fall", vld[0], 0);
    drain();
    w = 8'h7E;
    put_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) put_bit(0, w[i]);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", bsy[0], 0);
    rst_n = 1'b1;
    idle(0, 2);
    expect_word(0, 9'h81, 0, 0);
    send(0, 9'h81, 0, 2'b11);
    drain();
    rdy[2] = 1'b1;
    expect_word(2, 9'h1F, 0, 0);
    send(2, 9'h1F, 0, 2'b11);
    drain();
    for (int s = 0; s < 3; s++) begin
      rdy[s] = 1'b1;
      repeat (12) begin
        rw = 9'($urandom);
        bp = (PM[s] != 0) && ($urandom_range(0, 3) == 0);
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        expect_word(s, rw, bp, (SB[s] == 1) ? ~st[0] : ~(st[0] & st[1]));
        send(s, rw, bp, st);
        idle(s, $urandom_range(1, 2));
      end
      drain();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_DIV, default 427: clk cycles per bit; legal range 8..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset; synchronous and active-low.
REQ-007 rx  input  1  asynchronous serial line; idles high.
REQ-008 data_out  output  DATA_BITS  received word, LSB received first.
REQ-009 data_valid  output  1  data_out and status flags hold a word not yet accepted.
REQ-010 data_ready  input  1  consumer accepts the word in any cycle where data_valid=1 and data_ready=1.
REQ-011 parity_err  output  1  parity mismatch on the held word; valid only while data_valid=1.
REQ-012 frame_err  output  1  any stop bit sampled 0 on the held word; valid only while data_valid=1.
REQ-013 overrun  output  1  one-cycle pulse when a completed frame is discarded.
REQ-014 busy  output  1  high from start-bit detection until return to IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-016 FSM states SHALL be IDLE, START, DATA, PAR, STOP.
REQ-017 Bit-timer width SHALL be clog2(CLK_DIV); timer clears on every state entry.
REQ-018 IDLE->START SHALL occur when rx_s=0 and the armed flag=1; the armed flag sets whenever rx_s=1 in IDLE.
REQ-019 In START, at timer=CLK_DIV/2-1: rx_s=0 -> DATA; rx_s=1 -> IDLE (false start; nothing reported).
REQ-020 In DATA, PAR and STOP, each bit SHALL be sampled when timer=CLK_DIV-1, with the timer then cleared (mid-bit sampling).
REQ-021 DATA SHALL shift in DATA_BITS samples LSB-first, then go to PAR if PARITY!=0, else to STOP.
REQ-022 PAR SHALL compute parity_err: odd mode errs when the XOR of data and parity bit is 0; even mode errs when it is 1.
REQ-023 STOP SHALL sample STOP_BITS bits; frame_err is set if any of them is 0.
REQ-024 On the final stop sample the FSM SHALL return to IDLE; the armed flag clears if that sample is 0 (break/low line must return high before a new start).
REQ-025 Frame completion SHALL register data_out, parity_err and frame_err, and raise data_valid, on the clock edge after the final stop sample.
REQ-026 Frames carrying errors SHALL still be delivered, with their flags set.
REQ-027 data_valid SHALL stay high with data_out and flags stable until acceptance; it falls on the edge after acceptance.
REQ-028 On completion while data_valid=1 and data_ready=0: new frame discarded, held word unchanged, overrun=1 for one cycle.
REQ-029 On completion while data_valid=1 and data_ready=1 in the same cycle: old word accepted, new word loaded, data_valid stays 1, no overrun.
REQ-030 busy SHALL be 0 in IDLE and 1 in all other states.
REQ-031 Parity-related logic SHALL be absent (parity_err tied 0) when PARITY=0.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force: IDLE state, timer=0, armed=0, synchronizer=1, data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-033 Reset mid-frame SHALL discard the partial frame; reception resumes only after rx_s is seen high.

Verification (CLK_DIV=16 unless stated)
REQ-034 8N1 frame 0xA5, data_ready=1 -> data_valid pulses 1 cycle, data_out=0xA5, both error flags 0, valid edge exactly 1 cycle after stop-bit sample.
REQ-035 8E1 frame 0x3C with correct parity bit 0 -> parity_err=0; same frame with parity bit 1 -> parity_err=1, data_out=0x3C.
REQ-036 Stop bit driven 0 -> frame_err=1; rx held low 40 bits -> no further frames until rx returns high, then next frame 0x55 received correctly.
REQ-037 Low glitch of 4 cycles on idle rx -> no frame, busy returns to 0 by cycle CLK_DIV/2+3, data_valid stays 0.
REQ-038 Two back-to-back frames 0x11, 0x22 with data_ready=0 -> data_out=0x11 held, overrun pulses once; then data_ready=1 -> data_valid falls.
REQ-039 rst_n=0 asserted mid-DATA of 0x7E, released, then frame 0x81 -> only 0x81 delivered; DATA_BITS=5/STOP_BITS=2 build receives 0x1F.
